// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory request/acknowledge bus used by the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : MIPS32 program counter and instruction-fetch stage with
//               req/ack memory handshake and buffered branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                stall,
    input  wire                branch_valid,
    input  wire  [ADDR_W-1:0]  branch_target,
    pc_fetch_unit_if.master    imem,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  adder_a,
    output logic [ADDR_W-1:0]  adder_b,
    input  wire  [ADDR_W-1:0]  adder_sum,
    input  wire                adder_c_out,
    output logic               pc_wrap,
    output logic               misalign_err
);

    localparam logic [1:0]        c_st_idle = 2'd0;
    localparam logic [1:0]        c_st_req  = 2'd1;
    localparam logic [1:0]        c_st_out  = 2'd2;
    localparam logic [ADDR_W-1:0] c_step    = ADDR_W'(STEP);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_pend_valid;
    logic              w_pend_valid_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_nxt;
    logic              w_fetch_done;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_pc_wrap;
    logic              r_misalign;

    // Instructions are word aligned; the low byte-offset bits are dropped.
    assign w_branch_tgt = {branch_target[ADDR_W-1:2], 2'b00};

    assign adder_a       = r_pc;
    assign adder_b       = c_step;
    assign imem.imem_addr = r_pc;
    assign instr         = r_instr;
    assign instr_pc      = r_instr_pc;
    assign pc_wrap       = r_pc_wrap;
    assign misalign_err  = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_fetch_done     = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_req;
                if (branch_valid) begin
                    w_pc_nxt = w_branch_tgt;
                end
            end
            c_st_req: begin
                if (imem.imem_ack) begin
                    // A redirect seen during the request turns the returned word stale.
                    if (branch_valid) begin
                        w_pc_nxt         = w_branch_tgt;
                        w_pend_valid_nxt = 1'b0;
                    end else if (r_pend_valid) begin
                        w_pc_nxt         = r_pend_pc;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt     = adder_sum;
                        w_fetch_done = 1'b1;
                        w_state_nxt  = c_st_out;
                    end
                end else if (branch_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_pc_nxt    = w_branch_tgt;
                end
            end
            c_st_out: begin
                if (branch_valid) begin
                    w_pc_nxt    = w_branch_tgt;
                    w_state_nxt = c_st_req;
                end else if (!stall) begin
                    w_state_nxt = c_st_req;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        case (r_state)
            c_st_req: imem.imem_req = 1'b1;
            c_st_out: instr_valid   = 1'b1;
            default: begin
                imem.imem_req = 1'b0;
                instr_valid   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_pc_wrap    <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            if (w_fetch_done) begin
                r_instr    <= imem.imem_rdata;
                r_instr_pc <= r_pc;
            end
            r_pc_wrap  <= w_fetch_done & adder_c_out;
            r_misalign <= branch_valid & (|branch_target[1:0]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int c_addr_w = 10;

    logic                clk;
    logic                rst_n;
    logic                stall;
    logic                branch_valid;
    logic [c_addr_w-1:0] branch_target;
    logic                instr_valid;
    logic [31:0]         instr;
    logic [c_addr_w-1:0] instr_pc;
    logic [c_addr_w-1:0] adder_a;
    logic [c_addr_w-1:0] adder_b;
    logic [c_addr_w-1:0] adder_sum;
    logic                adder_c_out;
    logic                pc_wrap;
    logic                misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_unit_if #(.ADDR_W(c_addr_w)) imem_bus ();

    pc_fetch_unit #(
        .ADDR_W   (c_addr_w),
        .STEP     (4),
        .RESET_PC (10'h000)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem          (imem_bus.master),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_sum     (adder_sum),
        .adder_c_out   (adder_c_out),
        .pc_wrap       (pc_wrap),
        .misalign_err  (misalign_err)
    );

    // Ripple adder that sits beside the fetch stage
    assign {adder_c_out, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [c_addr_w-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: optional ack carrying addr-tagged data; branch is a one-cycle pulse.
    task automatic cycle(input bit ack);
        imem_bus.imem_ack   = ack;
        imem_bus.imem_rdata = ack ? tag(imem_bus.imem_addr) : 32'h0;
        @(posedge clk);
        #1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        branch_valid        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n               = 1'b0;
        stall               = 1'b0;
        branch_valid        = 1'b0;
        branch_target       = '0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",     32'(imem_bus.imem_req), 32'h0);
        check("rst_valid",   32'(instr_valid),       32'h0);
        check("rst_instr",   instr,                  32'h0);
        check("rst_adder_a", 32'(adder_a),           32'h000);
        check("rst_adder_b", 32'(adder_b),           32'h004);
        check("rst_wrap",    32'(pc_wrap),           32'h0);
        check("rst_misal",   32'(misalign_err),      32'h0);

        rst_n = 1'b1;
        cycle(1'b0);
        check("first_req", 32'(imem_bus.imem_req), 32'h1);

        // Sequential fetch with zero-wait memory
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", 32'(imem_bus.imem_addr), 32'(4 * i));
            cycle(1'b1);
            check("seq_valid", 32'(instr_valid),       32'h1);
            check("seq_pc",    32'(instr_pc),          32'(4 * i));
            check("seq_instr", instr,                  tag(10'(4 * i)));
            check("seq_noreq", 32'(imem_bus.imem_req), 32'h0);
            if (i < 2) begin
                cycle(1'b0);
                check("seq_gap", 32'(instr_valid), 32'h0);
            end
        end

        // Stall while holding instr_pc=0x008
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            check("stall_valid", 32'(instr_valid),       32'h1);
            check("stall_pc",    32'(instr_pc),          32'h008);
            check("stall_instr", instr,                  tag(10'h008));
            check("stall_noreq", 32'(imem_bus.imem_req), 32'h0);
        end
        stall = 1'b0;
        cycle(1'b0);
        check("post_stall_addr",  32'(imem_bus.imem_addr), 32'h00C);
        check("post_stall_req",   32'(imem_bus.imem_req),  32'h1);
        cycle(1'b1);
        check("fetch_c_pc", 32'(instr_pc), 32'h00C);
        cycle(1'b0);
        check("addr_10", 32'(imem_bus.imem_addr), 32'h010);

        // Branch during an outstanding request, ack delayed
        branch_target = 10'h100;
        branch_valid  = 1'b1;
        cycle(1'b0);
        check("pend_hold_addr", 32'(imem_bus.imem_addr), 32'h010);
        cycle(1'b0);
        cycle(1'b0);
        check("pend_hold_req", 32'(imem_bus.imem_req), 32'h1);
        cycle(1'b1);
        check("discard_valid", 32'(instr_valid),       32'h0);
        check("redir_addr",    32'(imem_bus.imem_addr), 32'h100);
        check("redir_req",     32'(imem_bus.imem_req),  32'h1);

        // Two redirects before the ack: last one wins
        branch_target = 10'h040;
        branch_valid  = 1'b1;
        cycle(1'b0);
        branch_target = 10'h080;
        branch_valid  = 1'b1;
        cycle(1'b0);
        check("two_br_hold", 32'(imem_bus.imem_addr), 32'h100);
        cycle(1'b1);
        check("two_br_valid", 32'(instr_valid),       32'h0);
        check("two_br_addr",  32'(imem_bus.imem_addr), 32'h080);
        cycle(1'b1);
        check("fetch_80_pc",    32'(instr_pc), 32'h080);
        check("fetch_80_instr", instr,         tag(10'h080));

        // Redirect from OUT to the top of the address space, then wrap
        branch_target = 10'h3FC;
        branch_valid  = 1'b1;
        cycle(1'b0);
        check("top_valid", 32'(instr_valid),       32'h0);
        check("top_addr",  32'(imem_bus.imem_addr), 32'h3FC);
        cycle(1'b1);
        check("top_pc",      32'(instr_pc), 32'h3FC);
        check("wrap_pulse",  32'(pc_wrap),  32'h1);
        check("wrap_addr_a", 32'(adder_a),  32'h000);
        cycle(1'b0);
        check("wrap_clear", 32'(pc_wrap),            32'h0);
        check("wrap_addr",  32'(imem_bus.imem_addr), 32'h000);

        // Misaligned redirect while stalled in OUT drops the held instruction
        cycle(1'b1);
        check("pre_mis_pc", 32'(instr_pc), 32'h000);
        check("no_rewrap",  32'(pc_wrap),  32'h0);
        stall         = 1'b1;
        branch_target = 10'h0A2;
        branch_valid  = 1'b1;
        cycle(1'b0);
        check("mis_pulse", 32'(misalign_err),       32'h1);
        check("mis_valid", 32'(instr_valid),        32'h0);
        check("mis_addr",  32'(imem_bus.imem_addr), 32'h0A0);
        stall = 1'b0;
        cycle(1'b0);
        check("mis_clear", 32'(misalign_err),       32'h0);
        check("mis_hold",  32'(imem_bus.imem_addr), 32'h0A0);

        // Asynchronous reset in the middle of a request
        rst_n = 1'b0;
        #1;
        check("async_req",   32'(imem_bus.imem_req),  32'h0);
        check("async_addr",  32'(imem_bus.imem_addr), 32'h000);
        check("async_valid", 32'(instr_valid),        32'h0);
        cycle(1'b1);
        check("rst_ack_ignored", 32'(instr_valid), 32'h0);
        rst_n = 1'b1;
        cycle(1'b0);
        check("restart_req",  32'(imem_bus.imem_req),  32'h1);
        check("restart_addr", 32'(imem_bus.imem_addr), 32'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the MIPS32 CPU. It holds the 10-bit instruction-memory PC and drives the ripple adder that computes PC+4. It also runs a req/ack handshake with instruction memory and presents each fetched word, with its PC, to decode. The adder sits beside this block combinationally: the adder's operands come from here, and its sum and carry-out return as the next-PC source.

## Interface
Parameters:
- ADDR_W, 10, PC / instruction-memory address width (matches adder width)
- STEP, 4, PC increment in bytes
- RESET_PC, 10'h000, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept; hold current instruction
- branch_valid  in  1  one-cycle redirect request
- branch_target  in  ADDR_W  redirect address
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  fetched instruction
- instr_pc  out  ADDR_W  PC of instr
- adder_a  out  ADDR_W  adder operand A (= pc)
- adder_b  out  ADDR_W  adder operand B (= STEP)
- adder_sum  in  ADDR_W  pc+STEP from adder
- adder_c_out  in  1  adder carry-out
- pc_wrap  out  1  one-cycle pulse: PC advanced past top of address space
- misalign_err  out  1  one-cycle pulse: branch_target[1:0] != 0

## Operation
- State register: IDLE, REQ, OUT.
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, state=IDLE, pending_valid=0.
  - All outputs 0, except adder_a=RESET_PC and adder_b=STEP.
- adder_a=pc and adder_b=STEP at all times (combinational). The next sequential PC is always adder_sum.
- IDLE: entered only from reset. Goes to REQ on the first clock edge after rst_n rises.
- REQ:
  - imem_req=1, imem_addr=pc. Both are held stable until imem_ack.
  - A request is never withdrawn.
- On imem_ack in REQ:
  - If no redirect is pending and branch_valid=0: instr<=imem_rdata, instr_pc<=pc, pc<=adder_sum, state<=OUT.
  - If pending_valid=1 or branch_valid=1: the returned word is discarded and instr_valid stays 0. pc<=redirect target, pending_valid<=0, state stays REQ.
- OUT:
  - instr_valid=1.
  - stall=1: hold instr, instr_pc and pc; stay in OUT.
  - stall=0: state<=REQ and instr_valid drops next cycle.
- Redirect handling:
  - branch_valid in OUT or IDLE: pc<=target, state<=REQ; any instr held in OUT is dropped, even if stall=1.
  - branch_valid in REQ without imem_ack: target is latched into pending_pc with pending_valid=1.
  - A later branch_valid before the ack overwrites pending_pc (last wins).
- Target alignment: the redirect target is branch_target with bits [1:0] forced to 0. If branch_target[1:0] != 0, misalign_err pulses for one cycle.
- Wrap-around:
  - When pc advances via adder_sum with adder_c_out=1 (e.g. 10'h3FC -> 10'h000), pc_wrap pulses for one cycle.
  - Wrap is not an error; fetch continues at 0.
- Reset mid-operation: immediate return to reset values. Any in-flight memory response is ignored, since imem_req=0 during reset.

## Timing
- Fetch latency: instr_valid rises 1 cycle after the imem_ack edge.
- Throughput: at most one instruction per 2 cycles (REQ+OUT), with a zero-wait memory that acks in the first REQ cycle.
- First fetch after reset:
  - imem_req rises at the 1st edge after rst_n deassert.
  - With immediate ack, instr_valid=1 at the 2nd edge.
- Redirect latency: the new address appears on imem_addr 1 cycle after branch_valid, or 1 cycle after the ack if a request was outstanding.
- pc_wrap and misalign_err are registered and high for exactly one cycle.
- All state changes occur on the clk rising edge. Reset is the only asynchronous path.

## Test plan
- Reset with RESET_PC=0, memory acks every request immediately returning addr-tagged data -> instr_pc sequence 0,4,8,C; instr_valid high every second cycle.
- stall=1 for 5 cycles while in OUT at instr_pc=0x008 -> instr/instr_pc constant, imem_req=0 throughout, next fetch address 0x00C.
- branch_valid with target 0x100 in REQ, ack delayed 3 cycles -> acked word at old PC discarded (no instr_valid), next imem_addr=0x100.
- Two branch_valid pulses (0x040 then 0x080) before a delayed ack -> next imem_addr=0x080.
- Sequential fetch at pc=0x3FC -> instr_pc=0x3FC delivered, pc_wrap pulses once, next imem_addr=0x000.
- branch_target=0x0A2 -> misalign_err one-cycle pulse, next imem_addr=0x0A0; rst_n low mid-REQ -> imem_req drops immediately, imem_addr=RESET_PC.
